// File: rtl/eaglesong_bit_matrix_seq.sv
// Bit-serial Eaglesong bit-matrix step: state_out[j] = XOR_k (M[k*16+j] & state_in[k]), one matrix bit per cycle.
// Optional feature: define EAGLESONG_BM_SEQ_ABORT_EN to add the abort input.
module eaglesong_bit_matrix_seq #(
    parameter int unsigned WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef EAGLESONG_BM_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [16*WORD_W-1:0]  state_in,
    output logic [7:0]            bm_index,
    input  logic                  bm_bit,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORD_W-1:0]  state_out
);

    localparam int unsigned N_WORDS = 16;
    localparam int unsigned STATE_W = N_WORDS * WORD_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                state_q;
    logic [7:0]          c_q;
    logic [WORD_W-1:0]   acc_q;
    logic [STATE_W-1:0]  cap_q;
    logic [STATE_W-1:0]  res_q;

    logic                abort_hit;
    logic [3:0]          j;
    logic [3:0]          k;
    logic [7:0]          c_nxt;
    logic [WORD_W-1:0]   word_k;
    logic [WORD_W-1:0]   t;
    logic [STATE_W-1:0]  res_fin;

`ifdef EAGLESONG_BM_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Datapath for the current matrix bit; res_fin is the result buffer with word j replaced by t.
    always_comb begin
        j       = c_q[7:4];
        k       = c_q[3:0];
        c_nxt   = c_q + 8'd1;
        word_k  = cap_q[32'(k) * WORD_W +: WORD_W];
        t       = acc_q ^ (bm_bit ? word_k : '0);
        res_fin = res_q;
        res_fin[32'(j) * WORD_W +: WORD_W] = t;
    end

    // Results go to a private buffer so state_out only changes on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            c_q       <= '0;
            acc_q     <= '0;
            cap_q     <= '0;
            res_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bm_index  <= '0;
            state_out <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cap_q    <= state_in;
                        c_q      <= '0;
                        acc_q    <= '0;
                        busy     <= 1'b1;
                        bm_index <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        c_q      <= '0;
                        acc_q    <= '0;
                        busy     <= 1'b0;
                        bm_index <= '0;
                        state_q  <= IDLE;
                    end else begin
                        c_q <= c_nxt;
                        if (k == 4'd15) begin
                            acc_q <= '0;
                            res_q <= res_fin;
                        end else begin
                            acc_q <= t;
                        end
                        if (c_q == 8'd255) begin
                            state_out <= res_fin;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            bm_index  <= '0;
                            state_q   <= DONE;
                        end else begin
                            bm_index <= {c_nxt[3:0], c_nxt[7:4]};
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
